spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arb_pkg.sv | 17 +
 rtl/spi_rr_arbiter.sv | 40 ++++
 rtl/spi_arbiter.sv | 168 ++++++++++++++++
 tb/tb_spi_arbiter.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared FSM encoding and default sizing for the SPI master arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_arb_pkg;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    // Arbiter FSM encoding, kept as plain constants so older tools can consume it.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_XFER  = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/spi_rr_arbiter.sv
// spi_rr_arbiter: combinational round-robin pick of the first set req at or after rr_ptr.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to consume the pick.
// Ports: req (level requests), rr_ptr (search start) in; pick (one-hot), vld (any req) out.
module spi_rr_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = $clog2(DEF_NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               vld
);

    // One extra bit so rr_ptr + k can exceed NUM_REQ-1 before the wrap.
    localparam int SW = PTR_W + 1;

    logic [SW-1:0] sel;
    logic          found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel = {1'b0, rr_ptr} + SW'(k);
            if (sel >= SW'(NUM_REQ)) begin
                sel = sel - SW'(NUM_REQ);
            end
            if (!found && req[sel[PTR_W-1:0]]) begin
                pick[sel[PTR_W-1:0]] = 1'b1;
                found                = 1'b1;
            end
        end
        vld = found;
    end

endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter sharing one SPI master among NUM_REQ requesters.
// Latency: gnt 1 cycle after req; done/rsp_data 1 cycle after m_cs is sampled high again.
// Backpressure: req is a level; an ungranted requester just keeps req high until served.
// Ports: clk, reset (async active-low); req/req_data in; gnt/done/rsp_data/err/busy out;
//        m_enable/m_data_in drive the master; m_data_out/m_cs are read back from it.
// Option: define SPI_ARB_TIMEOUT_EN to add a START watchdog that aborts with done+err.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
)(
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          err,
    output logic                          busy,
    output logic                          m_enable,
    output logic [DATA_WIDTH-1:0]         m_data_in,
    input  logic [DATA_WIDTH-1:0]         m_data_out,
    input  logic                          m_cs
);

    localparam int PTR_W = $clog2(NUM_REQ);

    state_t                 state_q,     state_d;
    logic [NUM_REQ-1:0]     gnt_q,       gnt_d;
    logic [NUM_REQ-1:0]     done_q,      done_d;
    logic [PTR_W-1:0]       idx_q,       idx_d;
    logic [PTR_W-1:0]       rr_ptr_q,    rr_ptr_d;
    logic [DATA_WIDTH-1:0]  m_data_in_q, m_data_in_d;
    logic [DATA_WIDTH-1:0]  rsp_data_q,  rsp_data_d;

    logic [NUM_REQ-1:0]     pick;
    logic                   pick_vld;
    logic [PTR_W-1:0]       pick_idx;
    logic [DATA_WIDTH-1:0]  pick_data;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]        wd_q, wd_d;
    logic                   err_q, err_d;
`endif

    spi_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .pick   (pick),
        .vld    (pick_vld)
    );

    // Encode the one-hot pick and mux out that requester's frame.
    always_comb begin
        pick_idx  = '0;
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                pick_idx  = PTR_W'(i);
                pick_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        idx_d       = idx_q;
        rr_ptr_d    = rr_ptr_q;
        m_data_in_d = m_data_in_q;
        rsp_data_d  = rsp_data_q;
        done_d      = '0;
`ifdef SPI_ARB_TIMEOUT_EN
        wd_d        = '0;
        err_d       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // The frame is latched here so later req_data changes cannot leak into the transfer.
                if (pick_vld) begin
                    gnt_d       = pick;
                    idx_d       = pick_idx;
                    m_data_in_d = pick_data;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                if (!m_cs) begin
                    state_d = ST_XFER;
`ifdef SPI_ARB_TIMEOUT_EN
                end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    // Master never selected the slave: abort, keep the previous rsp_data.
                    state_d = ST_DONE;
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
`endif
                end
            end
            ST_XFER: begin
                // done and rsp_data are registered together so rsp_data is valid during the pulse.
                if (m_cs) begin
                    state_d    = ST_DONE;
                    done_d     = gnt_q;
                    rsp_data_d = m_data_out;
                end
            end
            ST_DONE: begin
                gnt_d    = '0;
                rr_ptr_d = (idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : idx_q + PTR_W'(1);
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            done_q      <= '0;
            idx_q       <= '0;
            rr_ptr_q    <= '0;
            m_data_in_q <= '0;
            rsp_data_q  <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            wd_q        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            idx_q       <= idx_d;
            rr_ptr_q    <= rr_ptr_d;
            m_data_in_q <= m_data_in_d;
            rsp_data_q  <= rsp_data_d;
`ifdef SPI_ARB_TIMEOUT_EN
            wd_q        <= wd_d;
            err_q       <= err_d;
`endif
        end
    end

    // m_enable decodes straight from state so an async reset drops it immediately.
    assign m_enable  = (state_q == ST_START);
    assign busy      = (state_q != ST_IDLE);
    assign gnt       = gnt_q;
    assign done      = done_q;
    assign rsp_data  = rsp_data_q;
    assign m_data_in = m_data_in_q;
`ifdef SPI_ARB_TIMEOUT_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_arbiter.sv
`timescale 1ns/1ps
// tb_spi_arbiter: scoreboard bench for spi_arbiter with a behavioural SPI master.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_arbiter;

    localparam int NR       = 4;
    localparam int DW       = 8;
    localparam int TO       = 64;
    localparam int XFER_CYC = 12;

    logic              clk   = 1'b0;
    logic              reset = 1'b0;
    logic [NR-1:0]     req   = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR-1:0]     gnt, done;
    logic [DW-1:0]     rsp_data, m_data_in;
    logic [DW-1:0]     m_data_out;
    logic              err, busy, m_enable, m_cs;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [NR-1:0] done;
        logic          err;
        logic [DW-1:0] rsp;
        logic [DW-1:0] mdi;
        logic [DW-1:0] mosi;
    } ev_t;

    ev_t           done_obs[$];
    ev_t           done_exp[$];
    logic [NR-1:0] gnt_obs[$];
    logic [NR-1:0] gnt_exp[$];
    logic [NR-1:0] gnt_prev = '0;

    logic          master_on   = 1'b1;
    logic          master_busy = 1'b0;
    logic          use_fixed   = 1'b0;
    logic [DW-1:0] miso_pat    = '0;
    logic [DW-1:0] mosi_cap    = '0;
    logic [DW-1:0] last_rx     = '0;

    spi_arbiter #(
        .NUM_REQ        (NR),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .done       (done),
        .rsp_data   (rsp_data),
        .err        (err),
        .busy       (busy),
        .m_enable   (m_enable),
        .m_data_in  (m_data_in),
        .m_data_out (m_data_out),
        .m_cs       (m_cs)
    );

    always #5 clk = ~clk;

    // Behavioural master: on enable, latch MOSI frame, select the slave, shift, deselect.
    initial begin
        m_cs       = 1'b1;
        m_data_out = '0;
        forever begin
            @(posedge clk); #1;
            if (m_enable === 1'b1 && master_on) begin
                master_busy = 1'b1;
                mosi_cap    = m_data_in;
                repeat (2) @(posedge clk);
                #1 m_cs = 1'b0;
                repeat (XFER_CYC) @(posedge clk);
                #1 m_data_out = use_fixed ? miso_pat : ~mosi_cap;
                m_cs        = 1'b1;
                master_busy = 1'b0;
            end
        end
    end

    // Observer: records grant rising edges and every cycle with a done bit set.
    initial begin
        forever begin
            @(negedge clk);
            if (gnt != '0 && gnt_prev == '0) gnt_obs.push_back(gnt);
            if (done != '0) done_obs.push_back('{done, err, rsp_data, m_data_in, mosi_cap});
            gnt_prev = gnt;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    function automatic logic [DW-1:0] tx_of(int idx);
        return req_data[idx*DW +: DW];
    endfunction

    function automatic ev_t mk_ev(int idx, logic [DW-1:0] tx, logic [DW-1:0] rx);
        ev_t e;
        e.done = NR'(1) << idx;
        e.err  = 1'b0;
        e.rsp  = rx;
        e.mdi  = tx;
        e.mosi = tx;
        return e;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        req   = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({gnt, done, err, busy, m_enable} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got gnt=%b done=%b err=%b busy=%b en=%b, want all 0", gnt, done, err, busy, m_enable);
        end
        n_checks++;
        if ({m_data_in, rsp_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got m_data_in=%h rsp_data=%h, want 00 00", m_data_in, rsp_data);
        end
        reset = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({gnt, busy, m_enable, done} !== '0) begin
            n_fail++;
            $display("FAIL idle_hold: got gnt=%b busy=%b en=%b done=%b, want all 0", gnt, busy, m_enable, done);
        end
    endtask

    task automatic test_contention();
        int   order [5] = '{0, 1, 2, 3, 0};
        int   nd = 0;
        ev_t  o, e;
        logic [NR-1:0] g, ge;
        req_data  = 32'hD3C2_B1A0;
        use_fixed = 1'b0;
        gnt_obs.delete();
        done_obs.delete();
        foreach (order[k]) begin
            gnt_exp.push_back(NR'(1) << order[k]);
            done_exp.push_back(mk_ev(order[k], tx_of(order[k]), ~tx_of(order[k])));
        end
        req = 4'b1111;
        for (int c = 0; c < 600 && nd < 5; c++) begin
            @(negedge clk);
            if (done != '0) begin
                nd++;
                if (nd == 5) req = '0;
            end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (done_obs.size() != done_exp.size()) begin
            n_fail++;
            $display("FAIL contention_done_count: got %0d want %0d", done_obs.size(), done_exp.size());
        end
        while (done_obs.size() > 0 && done_exp.size() > 0) begin
            o = done_obs.pop_front();
            e = done_exp.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL contention_done: got done=%b err=%b rsp=%h mdi=%h mosi=%h want done=%b err=%b rsp=%h mdi=%h mosi=%h",
                         o.done, o.err, o.rsp, o.mdi, o.mosi, e.done, e.err, e.rsp, e.mdi, e.mosi);
            end
        end
        n_checks++;
        if (gnt_obs.size() != gnt_exp.size()) begin
            n_fail++;
            $display("FAIL contention_gnt_count: got %0d want %0d", gnt_obs.size(), gnt_exp.size());
        end
        while (gnt_obs.size() > 0 && gnt_exp.size() > 0) begin
            g  = gnt_obs.pop_front();
            ge = gnt_exp.pop_front();
            n_checks++;
            if (g !== ge) begin
                n_fail++;
                $display("FAIL contention_gnt_order: got %b want %b", g, ge);
            end
        end
        done_exp.delete();
        gnt_exp.delete();
    endtask

    task automatic test_single();
        int  nd = 0;
        ev_t o, e;
        req_data[7:0] = 8'hFA;
        use_fixed     = 1'b1;
        miso_pat      = 8'hF8;
        gnt_obs.delete();
        done_obs.delete();
        done_exp.push_back(mk_ev(0, 8'hFA, 8'hF8));
        req = 4'b0001;
        n_checks++;
        if (gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_gnt_early: got %b want 0000", gnt);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({gnt, busy, m_enable} !== {4'b0001, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL single_gnt_latency: got gnt=%b busy=%b en=%b want 0001 1 1", gnt, busy, m_enable);
        end
        req_data[7:0] = 8'h11;
        for (int c = 0; c < 200 && nd < 1; c++) begin
            @(negedge clk);
            if (done != '0) begin
                nd++;
                req = req & ~done;
            end
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (done_obs.size() != 1) begin
            n_fail++;
            $display("FAIL single_done_count: got %0d want 1", done_obs.size());
        end
        while (done_obs.size() > 0 && done_exp.size() > 0) begin
            o = done_obs.pop_front();
            e = done_exp.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL single_done: got done=%b err=%b rsp=%h mdi=%h mosi=%h want done=%b err=%b rsp=%h mdi=%h mosi=%h",
                         o.done, o.err, o.rsp, o.mdi, o.mosi, e.done, e.err, e.rsp, e.mdi, e.mosi);
            end
        end
        n_checks++;
        if (rsp_data !== 8'hF8 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rsp_hold: got rsp=%h busy=%b want f8 0", rsp_data, busy);
        end
        done_exp.delete();
        use_fixed = 1'b0;
    endtask

    task automatic test_wrap();
        int   order [3] = '{2, 3, 0};
        int   nd = 0;
        ev_t  o, e;
        logic [NR-1:0] g, ge;
        req_data = 32'h5E4D_3C2B;
        gnt_obs.delete();
        done_obs.delete();
        foreach (order[k]) begin
            gnt_exp.push_back(NR'(1) << order[k]);
            done_exp.push_back(mk_ev(order[k], tx_of(order[k]), ~tx_of(order[k])));
        end
        req = 4'b0100;
        for (int c = 0; c < 400 && nd < 3; c++) begin
            @(negedge clk);
            if (done != '0) begin
                nd++;
                req = req & ~done;
                if (nd == 1) req = 4'b1001;
            end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (done_obs.size() != done_exp.size()) begin
            n_fail++;
            $display("FAIL wrap_done_count: got %0d want %0d", done_obs.size(), done_exp.size());
        end
        while (done_obs.size() > 0 && done_exp.size() > 0) begin
            o = done_obs.pop_front();
            e = done_exp.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL wrap_done: got done=%b rsp=%h mdi=%h want done=%b rsp=%h mdi=%h",
                         o.done, o.rsp, o.mdi, e.done, e.rsp, e.mdi);
            end
        end
        while (gnt_obs.size() > 0 && gnt_exp.size() > 0) begin
            g  = gnt_obs.pop_front();
            ge = gnt_exp.pop_front();
            n_checks++;
            if (g !== ge) begin
                n_fail++;
                $display("FAIL wrap_gnt_order: got %b want %b", g, ge);
            end
        end
        done_exp.delete();
        gnt_exp.delete();
    endtask

    task automatic test_req_drop();
        int   nd = 0;
        logic dropped = 1'b0;
        ev_t  o, e;
        logic [NR-1:0] g, ge;
        req_data = 32'h8877_6655;
        gnt_obs.delete();
        done_obs.delete();
        gnt_exp.push_back(4'b0010);
        gnt_exp.push_back(4'b0100);
        done_exp.push_back(mk_ev(1, 8'h66, 8'h99));
        done_exp.push_back(mk_ev(2, 8'h77, 8'h88));
        req = 4'b0110;
        for (int c = 0; c < 400 && nd < 2; c++) begin
            @(negedge clk);
            if (!dropped && gnt == 4'b0010 && busy && !m_enable && !m_cs) begin
                req[1]  = 1'b0;
                dropped = 1'b1;
            end
            if (done != '0) begin
                nd++;
                req = req & ~done;
            end
        end
        repeat (30) @(negedge clk);
        n_checks++;
        if (dropped !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_reached_xfer: got %b want 1", dropped);
        end
        n_checks++;
        if (gnt_obs.size() != 2 || done_obs.size() != 2) begin
            n_fail++;
            $display("FAIL drop_counts: got gnts=%0d dones=%0d want 2 2", gnt_obs.size(), done_obs.size());
        end
        while (done_obs.size() > 0 && done_exp.size() > 0) begin
            o = done_obs.pop_front();
            e = done_exp.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL drop_done: got done=%b rsp=%h mdi=%h want done=%b rsp=%h mdi=%h",
                         o.done, o.rsp, o.mdi, e.done, e.rsp, e.mdi);
            end
        end
        while (gnt_obs.size() > 0 && gnt_exp.size() > 0) begin
            g  = gnt_obs.pop_front();
            ge = gnt_exp.pop_front();
            n_checks++;
            if (g !== ge) begin
                n_fail++;
                $display("FAIL drop_gnt_order: got %b want %b", g, ge);
            end
        end
        done_exp.delete();
        gnt_exp.delete();
    endtask

    task automatic test_reset_mid();
        int   nd = 0;
        logic in_xfer = 1'b0;
        ev_t  o, e;
        req_data = 32'h0000_003C;
        gnt_obs.delete();
        done_obs.delete();
        req = 4'b0001;
        for (int c = 0; c < 100 && !in_xfer; c++) begin
            @(negedge clk);
            in_xfer = busy && !m_enable && !m_cs;
        end
        n_checks++;
        if (in_xfer !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_reach_xfer: got %b want 1", in_xfer);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({gnt, done, err, busy, m_enable} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_ctrl: got gnt=%b done=%b err=%b busy=%b en=%b, want all 0", gnt, done, err, busy, m_enable);
        end
        n_checks++;
        if ({m_data_in, rsp_data} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_data: got m_data_in=%h rsp_data=%h, want 00 00", m_data_in, rsp_data);
        end
        req = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 100 && master_busy; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_checks++;
        if (done_obs.size() != 0 || master_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_no_done: got dones=%0d master_busy=%b want 0 0", done_obs.size(), master_busy);
        end
        gnt_obs.delete();
        done_exp.push_back(mk_ev(0, 8'h3C, 8'hC3));
        last_rx = 8'hC3;
        req = 4'b0001;
        @(posedge clk); #1;
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_mid_regrant: got %b want 0001", gnt);
        end
        for (int c = 0; c < 200 && nd < 1; c++) begin
            @(negedge clk);
            if (done != '0) begin
                nd++;
                req = req & ~done;
            end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (done_obs.size() != 1) begin
            n_fail++;
            $display("FAIL rst_mid_done_count: got %0d want 1", done_obs.size());
        end
        while (done_obs.size() > 0 && done_exp.size() > 0) begin
            o = done_obs.pop_front();
            e = done_exp.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rst_mid_done: got done=%b err=%b rsp=%h mdi=%h want done=%b err=%b rsp=%h mdi=%h",
                         o.done, o.err, o.rsp, o.mdi, e.done, e.err, e.rsp, e.mdi);
            end
        end
        done_exp.delete();
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int cyc = 0;
        master_on = 1'b0;
        req = 4'b0001;
        @(posedge clk); #1;
        n_checks++;
        if ({gnt, m_enable} !== {4'b0001, 1'b1}) begin
            n_fail++;
            $display("FAIL timeout_start: got gnt=%b en=%b want 0001 1", gnt, m_enable);
        end
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            cyc++;
            if (done != '0) break;
        end
        req = '0;
        n_checks++;
        if (cyc !== TO) begin
            n_fail++;
            $display("FAIL timeout_cycles: got %0d want %0d", cyc, TO);
        end
        n_checks++;
        if ({done, err, m_enable, rsp_data} !== {4'b0001, 1'b1, 1'b0, last_rx}) begin
            n_fail++;
            $display("FAIL timeout_abort: got done=%b err=%b en=%b rsp=%h want 0001 1 0 %h", done, err, m_enable, rsp_data, last_rx);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({done, err} !== '0) begin
            n_fail++;
            $display("FAIL timeout_pulse_width: got done=%b err=%b want 0000 0", done, err);
        end
        repeat (3) @(negedge clk);
        done_obs.delete();
        gnt_obs.delete();
        master_on = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_wrap();
        test_req_drop();
        test_reset_mid();
`ifdef SPI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
